// File: rtl/dmem_vec_loader_pkg.sv
// dmem_loader_pkg: shared types and default sizing for the vector loader.
// Optional bounds checking in the loader is enabled by DMEM_LOADER_BOUNDS_CHECK_EN.
package dmem_loader_pkg;

    localparam int VEC_W    = 192;
    localparam int ROM_SIZE = 150000;
    localparam int ADDR_W   = 18;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } loader_state_t;

    typedef struct packed {
        logic [VEC_W-1:0] data;
        logic             last;
    } vec_beat_t;

endpackage

// File: rtl/dmem_vec_loader_if.sv
// dmem_vec_loader_if: valid/ready vector stream toward the register file.
// master drives beats, slave applies back-pressure.
interface dmem_vec_loader_if
    import dmem_loader_pkg::*;
#(
    parameter int V = VEC_W
);

    logic         out_valid;
    logic         out_ready;
    logic [V-1:0] out_data;
    logic         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/dmem_vec_loader_vec_skid_fifo.sv
// vec_skid_fifo: DEPTH-entry circular buffer of vector beats.
// Head falls through; push and pop in the same cycle keep occupancy.
module vec_skid_fifo
    import dmem_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  vec_beat_t din,
    input  logic      pop,
    output vec_beat_t head,
    output logic      full,
    output logic      empty,
    output logic      one_left
);

    localparam int PW = $clog2(DEPTH);

    vec_beat_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Storage needs no reset: the head is only used while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign head     = mem[rd_ptr];
    assign full     = (cnt == (PW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign one_left = (cnt == (PW+1)'(1));

endmodule

// File: rtl/dmem_vec_loader.sv
// dmem_vec_loader: walks ROM words and streams them out through a small buffer.
// Define DMEM_LOADER_BOUNDS_CHECK_EN to add out-of-range zeroing and the err flag.
module dmem_vec_loader
    import dmem_loader_pkg::*;
#(
    parameter int V     = VEC_W,
    parameter int SIZE  = ROM_SIZE,
    parameter int AW    = ADDR_W,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          rom_vec_op,
    output logic [V-1:0]  rom_addr,
    input  logic [V-1:0]  rom_rd,
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
    output logic          err,
`endif
    dmem_vec_loader_if.master out_if
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic [AW-1:0] rem;
    logic          full;
    logic          empty;
    logic          one_left;
    logic          pop;
    logic          issue;
    vec_beat_t     tail;
    vec_beat_t     head;

    assign pop   = !empty && out_if.out_ready;
    assign issue = (state == S_FETCH) && (!full || pop);

`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
    logic oob;
    assign oob = ({1'b0, addr} >= (AW+1)'(SIZE));
`endif

    always_comb begin
        tail.last = (rem == AW'(1));
        tail.data = rom_rd;
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
        if (oob) begin
            tail.data = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            addr  <= '0;
            rem   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        addr  <= base_addr;
                        rem   <= count;
                        state <= (count != '0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        addr <= addr + AW'(1);
                        rem  <= rem - AW'(1);
                        if (rem == AW'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                // Leave as the final beat is popped so done lands one cycle later.
                S_DRAIN: begin
                    if (empty || (one_left && pop)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= 1'b0;
        end else if (issue && oob) begin
            err <= 1'b1;
        end
    end
`endif

    vec_skid_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .din     (tail),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .one_left(one_left)
    );

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign rom_vec_op = (state == S_FETCH);
    assign rom_addr   = {{(V-AW){1'b0}}, addr};

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = empty ? '0 : head.data;
    assign out_if.out_last  = !empty && head.last;

endmodule

// File: tb/tb_dmem_vec_loader.sv
// tb_dmem_vec_loader: randomized stream checks against a queue-based model.
// Build with DMEM_LOADER_BOUNDS_CHECK_EN to also cover the err flag.
module tb_dmem_vec_loader;
    import dmem_loader_pkg::*;

    localparam int V    = 192;
    localparam int AW   = 18;
    localparam int SIZE = 150000;
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    typedef struct {
        logic [V-1:0] data;
        logic         last;
        int           cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] count;
    logic          busy;
    logic          done;
    logic          rom_vec_op;
    logic [V-1:0]  rom_addr;
    logic [V-1:0]  rom_rd;
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
    logic          err;
`endif

    dmem_vec_loader_if #(.V(V)) bus ();

    dmem_vec_loader #(
        .V(V), .SIZE(SIZE), .AW(AW), .DEPTH(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_vec_op(rom_vec_op),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
        .err       (err),
`endif
        .out_if    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [V-1:0] rom_word(input logic [V-1:0] a);
        return {a[63:0] ^ 64'hA5A5_5A5A_C3C3_3C3C,
                a[63:0] * 64'h9E37_79B9_7F4A_7C15,
                a[63:0]};
    endfunction

    assign rom_rd = rom_word(rom_addr);

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    int    done_q[$];
    bit    valid_seen;
    logic  pv = 1'b0;
    logic  pl;
    logic [V-1:0] pd;
    beat_t mb;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_last !== pl) begin
                    errors++;
                    $display("FAIL hold_stable cyc %0d valid %b last %b data %h, required valid 1 last %b data %h",
                             cyc, bus.out_valid, bus.out_last, bus.out_data, pl, pd);
                end
            end
            if (bus.out_valid === 1'b1) valid_seen = 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                mb.data = bus.out_data;
                mb.last = bus.out_last;
                mb.cyc  = cyc;
                got_q.push_back(mb);
            end
            if (done === 1'b1) done_q.push_back(cyc);
            pv = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pl = bus.out_last;
        end
    end

    // Reference: beat i carries ROM[(base+i) mod 2^AW], zero if out of range when checked.
    task automatic build_exp(input int unsigned b, input int unsigned n);
        exp_q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            int unsigned a;
            beat_t e;
            a = (b + i) % (1 << AW);
            e.data = (BCHK && a >= SIZE) ? '0 : rom_word(V'(a));
            e.last = (i == n - 1);
            e.cyc  = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_q.delete();
        valid_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue_start(input int unsigned b, input int unsigned n, output int c);
        base_addr = AW'(b);
        count     = AW'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = cyc;
    endtask

    task automatic run_until_done(input int mode, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = (k % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            if (done_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        bus.out_ready = 1'b0;
        idle(3);
        checks++;
        if ({busy, done, rom_vec_op, bus.out_valid, bus.out_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000",
                     {busy, done, rom_vec_op, bus.out_valid, bus.out_last});
        end
        checks++;
        if (rom_addr !== '0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_buses addr %h data %h required 0", rom_addr, bus.out_data);
        end
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b required 0", err);
        end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int c;
        bit ok;
        clear_obs();
        build_exp(100, 4);
        bus.out_ready = 1'b1;
        issue_start(100, 4, c);
        checks++;
        if (busy !== 1'b1 || rom_vec_op !== 1'b1 || rom_addr !== V'(100)) begin
            errors++;
            $display("FAIL basic_fetch busy %b op %b addr %0d required 1 1 100", busy, rom_vec_op, rom_addr);
        end
        run_until_done(0, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout done seen %b required 1", ok);
        end
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last ||
                got_q[i].cyc != c + 1 + i) begin
                errors++;
                $display("FAIL basic_beat%0d data %h last %b cyc %0d required %h %b %0d", i,
                         got_q[i].data, got_q[i].last, got_q[i].cyc, exp_q[i].data, exp_q[i].last, c + 1 + i);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != c + 5) begin
            errors++;
            $display("FAIL basic_done pulses %0d first cyc %0d required 1 at %0d",
                     done_q.size(), (done_q.size() != 0) ? done_q[0] : -1, c + 5);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle busy %b required 0", busy);
        end
        idle(2);
    endtask

    task automatic test_stall();
        int c;
        int drops;
        bit ok;
        clear_obs();
        build_exp(100, 4);
        issue_start(100, 4, c);
        drops = 0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            bus.out_ready = (k % 3 == 0);
            @(posedge clk); #1;
            if (done_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) drops++;
        end
        checks++;
        if (!ok || drops != 0) begin
            errors++;
            $display("FAIL stall_busy done %b busy drops %0d required 1 and 0", ok, drops);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL stall_beat%0d data %h last %b required %h %b", i,
                         got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        bus.out_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_count_zero();
        int c;
        clear_obs();
        bus.out_ready = 1'b1;
        issue_start(0, 0, c);
        base_addr = AW'(5);
        count     = AW'(3);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(8);
        checks++;
        if (done_q.size() != 1 || done_q[0] != c) begin
            errors++;
            $display("FAIL zero_done pulses %0d first cyc %0d required 1 at %0d",
                     done_q.size(), (done_q.size() != 0) ? done_q[0] : -1, c);
        end
        checks++;
        if (valid_seen || got_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet valid_seen %b beats %0d busy %b required 0 0 0",
                     valid_seen, got_q.size(), busy);
        end
    endtask

    task automatic test_start_while_busy();
        int c;
        bit ok;
        clear_obs();
        build_exp(200, 4);
        bus.out_ready = 1'b1;
        issue_start(200, 4, c);
        base_addr = AW'(900);
        count     = AW'(2);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(0, 40, ok);
        checks++;
        if (!ok || got_q.size() != 4 || done_q[0] != c + 5) begin
            errors++;
            $display("FAIL busy_start done %b beats %0d done cyc %0d required 1 4 %0d",
                     ok, got_q.size(), (done_q.size() != 0) ? done_q[0] : -1, c + 5);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL busy_beat%0d data %h last %b required %h %b", i,
                         got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        idle(6);
        checks++;
        if (done_q.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_extra done pulses %0d busy %b required 1 0", done_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bit ok;
        clear_obs();
        bus.out_ready = 1'b1;
        issue_start(10, 8, c);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 3) break;
        end
        checks++;
        if (got_q.size() < 3 || done_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_pre beats %0d dones %0d required >=3 0", got_q.size(), done_q.size());
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, rom_vec_op, bus.out_valid, bus.out_last} !== 5'b0 ||
            rom_addr !== '0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outs ctrl %b addr %h data %h required 0",
                     {busy, done, rom_vec_op, bus.out_valid, bus.out_last}, rom_addr, bus.out_data);
        end
        rst = 1'b0;
        clear_obs();
        idle(10);
        checks++;
        if (done_q.size() != 0 || valid_seen) begin
            errors++;
            $display("FAIL rstmid_abort dones %0d valid_seen %b required 0 0", done_q.size(), valid_seen);
        end
        build_exp(0, 1);
        issue_start(0, 1, c);
        run_until_done(0, 20, ok);
        checks++;
        if (!ok || got_q.size() != 1 || done_q[0] != c + 2) begin
            errors++;
            $display("FAIL rstmid_after done %b beats %0d done cyc %0d required 1 1 %0d",
                     ok, got_q.size(), (done_q.size() != 0) ? done_q[0] : -1, c + 2);
        end else begin
            checks++;
            if (got_q[0].data !== exp_q[0].data || got_q[0].last !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_beat data %h last %b required %h 1",
                         got_q[0].data, got_q[0].last, exp_q[0].data);
            end
        end
        idle(2);
    endtask

    task automatic test_random();
        int unsigned b;
        int unsigned n;
        int c;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            b = $urandom_range(0, (1 << AW) - 1);
            n = $urandom_range(1, 12);
            if (it == 0) begin
                b = (1 << AW) - 3;
                n = 6;
            end
            clear_obs();
            build_exp(b, n);
            issue_start(b, n, c);
            run_until_done(2, 400, ok);
            checks++;
            if (!ok || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count done %b beats %0d required 1 %0d",
                         it, ok, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d data %h last %b required %h %b", it, i,
                             got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
                end
            end
            bus.out_ready = 1'b1;
            idle(2);
        end
    endtask

`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
    task automatic test_bounds();
        int c;
        bit ok;
        clear_obs();
        build_exp(149998, 4);
        bus.out_ready = 1'b1;
        issue_start(149998, 4, c);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bounds_clear got %b required 0", err);
        end
        idle(2);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bounds_early got %b required 0", err);
        end
        idle(1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bounds_set got %b required 1", err);
        end
        run_until_done(0, 20, ok);
        checks++;
        if (!ok || got_q.size() != 4 || done_q[0] != c + 5) begin
            errors++;
            $display("FAIL bounds_count done %b beats %0d required 1 4", ok, got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL bounds_beat%0d data %h last %b required %h %b", i,
                         got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bounds_sticky got %b required 1", err);
        end
        clear_obs();
        issue_start(0, 1, c);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bounds_restart got %b required 0", err);
        end
        run_until_done(0, 20, ok);
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_count_zero();
        test_start_while_busy();
        test_reset_mid();
        test_random();
`ifdef DMEM_LOADER_BOUNDS_CHECK_EN
        test_bounds();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_vec_loader.md
Name: dmem_vec_loader

Overview:
- Sequencing load stage directly downstream of the vector data ROM.
- On a start command it walks `count` consecutive ROM addresses from `base_addr`. It captures each V-bit vector the ROM returns combinationally.
- Captured vectors are streamed to the vector register-file write port over a valid/ready handshake.
- A 2-entry buffer decouples the ROM walk from consumer back-pressure, so throughput is 1 vector/cycle when the consumer is ready.

Parameters:
- V, 192, vector width in bits (matches ROM word width)
- SIZE, 150000, ROM depth in words
- AW, 18, internal address/count width (ceil(log2(SIZE)))
- DEPTH, 2, output buffer entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse, sampled only in IDLE
- base_addr  in  AW  first ROM word index
- count  in  AW  number of vectors to load
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after last beat handshaken (or immediately for count=0)
- rom_vec_op  out  1  high while FETCH is issuing, else 0
- rom_addr  out  V  ROM word index, zero-extended from AW bits
- rom_rd  in  V  ROM read data, combinational function of rom_addr
- out_valid  out  1  buffer head valid
- out_ready  in  1  consumer accepts head
- out_data  out  V  buffer head vector
- out_last  out  1  head is the final vector of the command

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Buffer is flushed, address/remaining registers cleared. Reset mid-command aborts with no done pulse.
- FSM states:
  - IDLE: if start then addr<=base_addr, rem<=count. Go to FETCH if count!=0, else DONE.
  - FETCH: issue when buffer not full, or full with a pop this cycle.
    - Issue: capture rom_rd into the tail with last=(rem==1), addr<=addr+1 (mod 2^AW), rem<=rem-1.
    - When rem reaches 0 after an issue, go to DRAIN.
  - DRAIN: wait until buffer is empty (last entry popped), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in FETCH, DRAIN, DONE.
- rom_addr = {zeros, addr} in all states; rom_vec_op=1 only in FETCH.
- Latency: start at cycle T gives the first out_valid at T+2. With out_ready held high, one beat per cycle and done at T+count+2.
- Handshake:
  - Beat transfers when out_valid & out_ready.
  - out_data/out_last stay stable while out_valid & !out_ready.
  - out_valid never drops without a transfer.
- Buffer: circular, DEPTH entries. Simultaneous push and pop when full is legal and keeps occupancy constant. No push when full without a pop.
- start while busy is ignored, with no effect on state.
- count=0: IDLE->DONE, done at T+1, no beats, out_valid stays 0.
- Address wrap: base_addr+count beyond 2^AW wraps to 0. Addresses >= SIZE are the caller's error unless the optional feature is enabled.

Optional Feature:
- Macro: DMEM_LOADER_BOUNDS_CHECK_EN.
- Defined:
  - Adds output `err` (1 bit, reset 0).
  - Any issue with addr >= SIZE pushes an all-zero vector instead of rom_rd and sets err sticky.
  - err clears only on rst or on the next accepted start.
  - Beat count and timing are unchanged.
- Undefined: no err port. rom_rd is captured unconditionally.

Decomposition:
- Package dmem_loader_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} loader_state_t
  - localparams for V, SIZE, AW defaults
  - typedef struct {logic [V-1:0] data; logic last;} vec_beat_t
- One natural sub-module: vec_skid_fifo.
  - DEPTH-entry synchronous FIFO of vec_beat_t with push/pop/full/empty.
  - First-word-fall-through head.

Test Plan:
- Reset mid-FETCH (base=10, count=8, rst asserted after 3 beats) -> next cycle all outputs 0, no done pulse. New start base=0, count=1 then completes normally.
- base=100, count=4, out_ready=1 constantly, ROM word k = k -> out_data 100,101,102,103 on consecutive cycles starting start+2. out_last on 103. done at start+6.
- Same command with out_ready toggling 1,0,0,1,... -> no lost or duplicated beats. Data is held stable across stall cycles, order is preserved, busy stays high until done.
- count=0 -> done one cycle after start, out_valid never asserted. A second start during that DONE cycle is ignored.
- start while busy with different base_addr -> original 4-beat sequence unaffected.
- With DMEM_LOADER_BOUNDS_CHECK_EN: base=149998, count=4 -> beats ROM[149998], ROM[149999], 0, 0. err=1 from the third issue, cleared by the next accepted start.
